// File: rtl/daq_pkg.sv
// Shared constants and page-id helpers for the DAQ event-buffer page scheduler.
package daq_pkg;

  localparam int PAGE_ID_W = 6;
  localparam int MAX_PAGES = 64;
  localparam int LEN_W_DEF = 11;

  typedef enum logic [1:0] {
    PS_512  = 2'd0,
    PS_1024 = 2'd1,
    PS_2048 = 2'd2
  } page_size_e;

  // Encoding 3 falls into the default branch and behaves like PS_2048.
  function automatic logic [6:0] page_count(input logic [1:0] ps);
    case (ps)
      PS_512:  return 7'd64;
      PS_1024: return 7'd32;
      default: return 7'd16;
    endcase
  endfunction

  function automatic logic [PAGE_ID_W-1:0] next_page(input logic [PAGE_ID_W-1:0] id,
                                                     input logic [1:0] ps);
    logic [6:0] mask;
    mask = page_count(ps) - 7'd1;
    return (id + 6'd1) & mask[PAGE_ID_W-1:0];
  endfunction

endpackage

// File: rtl/daq_rr_arbiter.sv
// Combinational round-robin pick: first eligible engine at or after ptr_i, with wrap.
module daq_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] elig_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [PTR_W-1:0] idx_o
);

  logic             found;
  logic [PTR_W-1:0] j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = '0;
    for (int off = 0; off < N_REQ; off++) begin
      j = PTR_W'((int'(ptr_i) + off) % N_REQ);
      if (!found && elig_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = j;
      end
    end
  end

endmodule

// File: rtl/daq_page_scheduler.sv
// Round-robin page allocator for the shared DAQ event buffer with in-order retirement
// of out-of-order commits to a single reader.
module daq_page_scheduler #(
  parameter int N_REQ = 4,
  parameter int LEN_W = daq_pkg::LEN_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [1:0]             page_size,
  input  logic [N_REQ-1:0]       req,
  output logic [N_REQ-1:0]       grant,
  output logic [5:0]             grant_page,
  input  logic [N_REQ-1:0]       commit,
  input  logic [N_REQ*LEN_W-1:0] commit_len,
  output logic                   rd_valid,
  output logic [5:0]             rd_page,
  output logic [LEN_W-1:0]       rd_len,
  input  logic                   rd_release,
  output logic [6:0]             n_used,
  output logic                   full,
  output logic                   empty,
  output logic                   commit_err
);
  import daq_pkg::*;

  localparam int RR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [1:0]           page_size_q, page_size_d;
  logic [5:0]           alloc_ptr_q, alloc_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [6:0]           n_used_q, n_used_d;
  logic [N_REQ-1:0]     owned_q, owned_d;
  logic [5:0]           own_page_q [N_REQ];
  logic [MAX_PAGES-1:0] committed_q, committed_d;
  logic [LEN_W-1:0]     len_q [MAX_PAGES];
  logic [RR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic                 commit_err_q, commit_err_d;
  logic [N_REQ-1:0]     grant_q;
  logic [5:0]           grant_page_q, grant_page_d;
  logic                 rd_valid_q, rd_valid_d;
  logic [5:0]           rd_page_q;
  logic [LEN_W-1:0]     rd_len_q, rd_len_d;
  logic                 full_q, full_d, empty_q, empty_d;

  logic [N_REQ-1:0] elig, arb_gnt, gnt_now, commit_ok;
  logic [RR_W-1:0]  arb_idx;
  logic             do_grant, do_release;

  assign elig       = req & ~owned_q;
  assign do_grant   = (|elig) && !full_q;
  assign gnt_now    = do_grant ? arb_gnt : '0;
  assign commit_ok  = commit & owned_q;
  assign do_release = rd_release && rd_valid_q;

  daq_rr_arbiter #(.N_REQ(N_REQ), .PTR_W(RR_W)) u_arb (
    .elig_i (elig),
    .ptr_i  (rr_ptr_q),
    .gnt_o  (arb_gnt),
    .idx_o  (arb_idx)
  );

  always_comb begin
    owned_d      = (owned_q & ~commit_ok) | gnt_now;
    committed_d  = committed_q;
    commit_err_d = commit_err_q | (|(commit & ~owned_q));
    alloc_ptr_d  = do_grant ? next_page(alloc_ptr_q, page_size_q) : alloc_ptr_q;
    rd_ptr_d     = do_release ? next_page(rd_ptr_q, page_size_q) : rd_ptr_q;
    n_used_d     = n_used_q + {6'd0, do_grant} - {6'd0, do_release};
    rr_ptr_d     = rr_ptr_q;
    if (do_grant)
      rr_ptr_d = (int'(arb_idx) == N_REQ - 1) ? '0 : arb_idx + RR_W'(1);
    // The page size may only change while nothing is allocated or owned.
    page_size_d  = ((n_used_q == 7'd0) && (owned_q == '0)) ? page_size : page_size_q;
    full_d       = (n_used_d == page_count(page_size_d));
    empty_d      = (n_used_d == 7'd0);
    grant_page_d = do_grant ? alloc_ptr_q : 6'd0;

    for (int i = 0; i < N_REQ; i++)
      if (commit_ok[i]) committed_d[own_page_q[i]] = 1'b1;
    if (do_release) committed_d[rd_ptr_q] = 1'b0;

    // Forward a length written this cycle so rd_len lines up with rd_valid.
    rd_valid_d = committed_d[rd_ptr_d];
    rd_len_d   = len_q[rd_ptr_d];
    for (int i = 0; i < N_REQ; i++)
      if (commit_ok[i] && (own_page_q[i] == rd_ptr_d))
        rd_len_d = commit_len[i*LEN_W +: LEN_W];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      page_size_q  <= page_size;
      alloc_ptr_q  <= '0;
      rd_ptr_q     <= '0;
      n_used_q     <= '0;
      owned_q      <= '0;
      committed_q  <= '0;
      rr_ptr_q     <= '0;
      commit_err_q <= 1'b0;
      grant_q      <= '0;
      grant_page_q <= '0;
      rd_valid_q   <= 1'b0;
      rd_page_q    <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
    end else begin
      page_size_q  <= page_size_d;
      alloc_ptr_q  <= alloc_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      n_used_q     <= n_used_d;
      owned_q      <= owned_d;
      committed_q  <= committed_d;
      rr_ptr_q     <= rr_ptr_d;
      commit_err_q <= commit_err_d;
      grant_q      <= gnt_now;
      grant_page_q <= grant_page_d;
      rd_valid_q   <= rd_valid_d;
      rd_page_q    <= rd_ptr_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
    end
  end

  // Page ids and lengths are payload; their validity is tracked by owned/committed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_now[i])   own_page_q[i] <= alloc_ptr_q;
      if (commit_ok[i]) len_q[own_page_q[i]] <= commit_len[i*LEN_W +: LEN_W];
    end
    rd_len_q <= rd_len_d;
  end

  assign grant      = grant_q;
  assign grant_page = grant_page_q;
  assign rd_valid   = rd_valid_q;
  assign rd_page    = rd_page_q;
  assign rd_len     = rd_len_q;
  assign n_used     = n_used_q;
  assign full       = full_q;
  assign empty      = empty_q;
  assign commit_err = commit_err_q;

endmodule
